// File: rtl/wb_io_ctrl.sv
// Wishbone I/O interconnect: one-hot slave select, STB/ACK/data routing,
// one-cycle idle gap after each access, and timeout termination with a sticky fault record.
module wb_io_ctrl #(
  parameter int unsigned NSLV   = 4,
  parameter int unsigned TMO    = 15,
  parameter logic [31:0] TMODAT = 32'hFFFF_FFFF
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 STB_I,
  input  logic                 WE_I,
  input  logic [NSLV-1:0]      ADR_I,
  output logic                 ACK_O,
  output logic [31:0]          DAT_O,
  output logic [NSLV-1:0]      s_STB_O,
  input  logic [NSLV-1:0]      s_ACK_I,
  input  logic [32*NSLV-1:0]   s_DAT_I,
  input  logic                 err_clr,
  output logic                 err,
  output logic [NSLV-1:0]      err_slv,
  output logic                 busy
);

  localparam int unsigned CW = 8;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_TOUT = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [NSLV-1:0] err_slv_q, err_slv_d;

  logic [NSLV-1:0] grant_c;
  logic            nosel_c;
  logic            sel_ack_c;
  logic [DW-1:0]   sel_dat_c;
  logic            ack_c;
  logic [NSLV-1:0] stb_c;
  logic [DW-1:0]   dat_c;

  // Write enable only passes to the slaves outside this block.
  logic unused_we;
  assign unused_we = WE_I;

  // Lowest-index set address bit wins the grant.
  always_comb begin
    logic found;
    grant_c = '0;
    found   = 1'b0;
    for (int k = 0; k < int'(NSLV); k++) begin
      if (ADR_I[k] && !found) begin
        grant_c[k] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign nosel_c   = (ADR_I == '0);
  assign sel_ack_c = |(s_ACK_I & grant_c);

  // Read data of the granted slave (grant is one-hot or zero).
  always_comb begin
    sel_dat_c = '0;
    for (int k = 0; k < int'(NSLV); k++) begin
      if (grant_c[k]) sel_dat_c = sel_dat_c | s_DAT_I[DW*k +: DW];
    end
  end

  // Next-state, counter, error record and routed outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    err_slv_d = err_slv_q;
    ack_c     = 1'b0;
    stb_c     = '0;
    dat_c     = '0;

    case (state_q)
      S_IDLE: begin
        stb_c = STB_I ? grant_c : '0;
        ack_c = STB_I & (nosel_c | sel_ack_c);
        dat_c = sel_dat_c;
        if (STB_I) begin
          if (ack_c) begin
            state_d = S_GAP;
            cnt_d   = '0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(1);
          end
        end
      end
      S_WAIT: begin
        stb_c = STB_I ? grant_c : '0;
        ack_c = STB_I & (nosel_c | sel_ack_c);
        dat_c = sel_dat_c;
        if (!STB_I) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (ack_c) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else if (cnt_q == CW'(TMO - 1)) begin
          state_d = S_TOUT;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_TOUT: begin
        ack_c   = 1'b1;
        dat_c   = TMODAT;
        state_d = S_GAP;
        cnt_d   = '0;
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A timeout sets the record and wins over a simultaneous clear.
    if (state_q == S_TOUT) begin
      err_d = 1'b1;
      if (!err_q || err_clr) err_slv_d = grant_c;
    end else if (err_clr) begin
      err_d     = 1'b0;
      err_slv_d = '0;
    end
  end

  // State, counter and error registers with synchronous active-low reset.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      err_slv_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      err_slv_q <= err_slv_d;
    end
  end

  assign ACK_O   = RST_I & ack_c;
  assign s_STB_O = {NSLV{RST_I}} & stb_c;
  assign DAT_O   = dat_c;
  assign busy    = (state_q == S_WAIT) || (state_q == S_TOUT);
  assign err     = err_q;
  assign err_slv = err_slv_q;

endmodule

// File: tb/tb_wb_io_ctrl.sv
// Self-checking bench for wb_io_ctrl: directed scenarios plus randomized accesses
// checked against a transaction-level expectation model.
module tb_wb_io_ctrl;

  localparam int unsigned NSLV   = 4;
  localparam int unsigned TMO    = 15;
  localparam logic [31:0] TMODAT = 32'hFFFF_FFFF;
  localparam int          NEVER  = 1000;

  logic                CLK_I = 1'b0;
  logic                RST_I;
  logic                STB_I;
  logic                WE_I;
  logic [NSLV-1:0]     ADR_I;
  logic                ACK_O;
  logic [31:0]         DAT_O;
  logic [NSLV-1:0]     s_STB_O;
  logic [NSLV-1:0]     s_ACK_I;
  logic [32*NSLV-1:0]  s_DAT_I;
  logic                err_clr;
  logic                err;
  logic [NSLV-1:0]     err_slv;
  logic                busy;

  int n_cmp = 0;
  int n_mis = 0;

  // Expected sticky error record.
  logic            m_err;
  logic [NSLV-1:0] m_slv;

  wb_io_ctrl #(.NSLV(NSLV), .TMO(TMO), .TMODAT(TMODAT)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .STB_I(STB_I), .WE_I(WE_I), .ADR_I(ADR_I),
    .ACK_O(ACK_O), .DAT_O(DAT_O), .s_STB_O(s_STB_O), .s_ACK_I(s_ACK_I),
    .s_DAT_I(s_DAT_I), .err_clr(err_clr), .err(err), .err_slv(err_slv), .busy(busy)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK_I);
    #1;
  endtask

  function automatic int first_bit(input logic [NSLV-1:0] a);
    for (int k = 0; k < int'(NSLV); k++) if (a[k]) return k;
    return -1;
  endfunction

  task automatic rand_slaves();
    for (int k = 0; k < int'(NSLV); k++) s_DAT_I[32*k +: 32] = $urandom;
    s_ACK_I = NSLV'($urandom);
  endtask

  task automatic chk_err();
    chk("err", 32'(err), 32'(m_err));
    chk("err_slv", 32'(err_slv), 32'(m_slv));
  endtask

  // One bus-idle cycle, optionally pulsing err_clr.
  task automatic idle_cycle(input bit clr);
    STB_I = 1'b0; ADR_I = '0; err_clr = clr; rand_slaves();
    @(negedge CLK_I);
    chk("idle_stb", 32'(s_STB_O), 32'h0);
    chk("idle_ack", 32'(ACK_O), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk_err();
    step();
    if (clr) begin m_err = 1'b0; m_slv = '0; end
    err_clr = 1'b0;
  endtask

  // One access: granted slave acks from strobe cycle lat on (lat>=TMO: never),
  // abort_at>0 drops STB at that cycle, clr_at pulses err_clr at that cycle.
  task automatic run_access(input logic [NSLV-1:0] adr, input int lat, input int abort_at,
                            input bit hold_gap, input int clr_at);
    int gi, done_i, last;
    bit nosel, tmo_hit, stb, is_tout, clr;
    logic [NSLV-1:0] g;
    logic [31:0] exp_dat;
    gi      = first_bit(adr);
    nosel   = (gi < 0);
    g       = nosel ? '0 : NSLV'(1 << gi);
    tmo_hit = !nosel && lat >= int'(TMO);
    done_i  = nosel ? 0 : (tmo_hit ? int'(TMO) : lat);
    last    = (abort_at > 0) ? abort_at : done_i;
    for (int i = 0; i <= last; i++) begin
      stb     = !(abort_at > 0 && i == abort_at);
      is_tout = tmo_hit && i == int'(TMO);
      clr     = (i == clr_at);
      STB_I = stb; ADR_I = adr; WE_I = 1'($urandom); err_clr = clr;
      rand_slaves();
      if (!nosel) s_ACK_I[gi] = !tmo_hit && i >= lat;
      @(negedge CLK_I);
      exp_dat = is_tout ? TMODAT : (nosel ? 32'h0 : s_DAT_I[32*gi +: 32]);
      chk("s_stb", 32'(s_STB_O), (stb && !is_tout) ? 32'(g) : 32'h0);
      chk("ack", 32'(ACK_O), 32'(stb && i == done_i));
      if (stb && i == done_i) chk("dat", DAT_O, exp_dat);
      chk("busy", 32'(busy), 32'(i > 0));
      chk_err();
      step();
      if (is_tout) begin
        if (!m_err || clr) m_slv = g;
        m_err = 1'b1;
      end else if (clr) begin
        m_err = 1'b0; m_slv = '0;
      end
    end
    err_clr = 1'b0;
    if (abort_at <= 0) begin
      STB_I = hold_gap; rand_slaves();
      @(negedge CLK_I);
      chk("gap_stb", 32'(s_STB_O), 32'h0);
      chk("gap_ack", 32'(ACK_O), 32'h0);
      chk("gap_dat", DAT_O, 32'h0);
      chk("gap_busy", 32'(busy), 32'h0);
      chk_err();
      step();
    end
  endtask

  initial begin
    RST_I = 1'b0; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 4'b0010; err_clr = 1'b0;
    s_ACK_I = '0; s_DAT_I = '0;
    m_err = 1'b0; m_slv = '0;

    // Reset held with a strobe pending.
    for (int r = 0; r < 2; r++) begin
      step();
      rand_slaves();
      @(negedge CLK_I);
      chk("rst_stb", 32'(s_STB_O), 32'h0);
      chk("rst_ack", 32'(ACK_O), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
    end
    step();
    RST_I = 1'b1;

    run_access(4'b0010, 0, 0, 1'b0, -1);          // zero-wait
    run_access(4'b0110, 3, 0, 1'b0, -1);          // wait states, priority
    run_access(4'b1000, NEVER, 0, 1'b0, -1);      // timeout, first fault
    run_access(4'b0001, NEVER, 0, 1'b1, -1);      // second fault keeps first
    idle_cycle(1'b1);                              // clear
    idle_cycle(1'b0);
    run_access(4'b0000, 0, 0, 1'b0, -1);          // no select
    run_access(4'b1000, NEVER, 5, 1'b0, -1);      // abort
    run_access(4'b0100, NEVER, 0, 1'b0, int'(TMO)); // clear collides with timeout
    run_access(4'b0001, int'(TMO) - 1, 0, 1'b0, -1); // ack on last allowed cycle

    // Reset in the middle of a waiting access.
    STB_I = 1'b1; ADR_I = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      rand_slaves(); s_ACK_I[2] = 1'b0;
      step();
    end
    RST_I = 1'b0;
    @(negedge CLK_I);
    chk("mrst_stb", 32'(s_STB_O), 32'h0);
    chk("mrst_ack", 32'(ACK_O), 32'h0);
    step();
    RST_I = 1'b1; m_err = 1'b0; m_slv = '0;
    idle_cycle(1'b0);
    run_access(4'b0100, NEVER, 0, 1'b0, -1);      // full-length timeout after reset

    // Randomized accesses.
    for (int n = 0; n < 60; n++) begin
      logic [NSLV-1:0] adr;
      int lat, ab, clr_at, sel, d;
      adr = NSLV'($urandom);
      sel = $urandom_range(0, 3);
      lat = (sel == 0) ? NEVER : (sel == 1) ? $urandom_range(0, TMO - 1) : $urandom_range(0, 3);
      d   = (adr == '0) ? 0 : ((lat >= int'(TMO)) ? int'(TMO) : lat);
      ab  = ($urandom_range(0, 5) == 0 && d >= 2) ? $urandom_range(1, d - 1) : 0;
      clr_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, d) : -1;
      run_access(adr, lat, ab, 1'($urandom), clr_at);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
